// File: rtl/i2c_bus_sequencer.sv
// Schedules switch polling, LED/FND mirroring and host writes onto one transaction-level I2C master core.
// Owns arbitration, retry, watchdog timeout and NACK accounting; never drives SDA/SCL.
module i2c_bus_sequencer #(
    parameter int         POLL_CYCLES    = 1000000,
    parameter logic [6:0] LED_ADDR       = 7'h55,
    parameter logic [6:0] FND_ADDR       = 7'h56,
    parameter logic [6:0] SW_ADDR        = 7'h57,
    parameter int         MAX_RETRY      = 2,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       host_req,
    input  logic [6:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_gnt,
    output logic       host_done,
    output logic       host_err,
    output logic       m_start,
    output logic [6:0] m_addr,
    output logic       m_rw,
    output logic [7:0] m_wdata,
    input  logic       m_busy,
    input  logic       m_done,
    input  logic       m_ack_err,
    input  logic [7:0] m_rdata,
    output logic [7:0] sw_value,
    output logic [7:0] nack_count,
    output logic [2:0] seq_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;

    localparam logic [1:0] SL_SW   = 2'd0;
    localparam logic [1:0] SL_LED  = 2'd1;
    localparam logic [1:0] SL_FND  = 2'd2;
    localparam logic [1:0] SL_HOST = 2'd3;

    localparam int TW = $clog2(POLL_CYCLES);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [2:0]    state;
    logic [1:0]    slot;
    logic [TW-1:0] poll_timer;
    logic          poll_pending;
    logic [RW-1:0] retry_cnt;
    logic          last_host;
    logic [6:0]    haddr_q;
    logic [7:0]    hdata_q;
    logic [WW-1:0] wd;
    logic          abandoned;

    logic poll_wrap, poll_win, host_win, txn_ok, txn_fail;

    assign poll_wrap = enable && (poll_timer == TW'(POLL_CYCLES - 1));
    // On a collision the side that lost last time wins.
    assign poll_win  = (state == S_IDLE) && enable && poll_pending && (!host_req || last_host);
    assign host_win  = (state == S_IDLE) && host_req && !poll_win;
    assign txn_ok    = (state == S_WAIT) && m_done && !m_ack_err;
    assign txn_fail  = (state == S_WAIT) &&
                       ((m_done && m_ack_err) || (!m_done && (wd == WW'(TIMEOUT_CYCLES - 1))));
    assign seq_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_timer <= '0;
        end else if (!enable || poll_wrap) begin
            poll_timer <= '0;
        end else begin
            poll_timer <= poll_timer + TW'(1);
        end
    end

    // Cleared on grant so a wrap during a running sequence stays pending; a new wrap wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_pending <= 1'b0;
        end else if (poll_wrap) begin
            poll_pending <= 1'b1;
        end else if ((state == S_IDLE) && (!enable || poll_win)) begin
            poll_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            slot       <= SL_SW;
            retry_cnt  <= '0;
            last_host  <= 1'b0;
            haddr_q    <= '0;
            hdata_q    <= '0;
            wd         <= '0;
            abandoned  <= 1'b0;
            m_start    <= 1'b0;
            m_addr     <= '0;
            m_rw       <= 1'b0;
            m_wdata    <= '0;
            host_gnt   <= 1'b0;
            host_done  <= 1'b0;
            host_err   <= 1'b0;
            sw_value   <= '0;
            nack_count <= '0;
        end else begin
            m_start   <= 1'b0;
            host_gnt  <= 1'b0;
            host_done <= 1'b0;
            host_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    retry_cnt <= '0;
                    if (poll_win) begin
                        slot      <= SL_SW;
                        last_host <= 1'b0;
                        state     <= S_ISSUE;
                    end else if (host_win) begin
                        host_gnt  <= 1'b1;
                        haddr_q   <= host_addr;
                        hdata_q   <= host_wdata;
                        slot      <= SL_HOST;
                        last_host <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!m_busy) begin
                        m_start <= 1'b1;
                        wd      <= '0;
                        state   <= S_WAIT;
                        case (slot)
                            SL_SW:   begin m_addr <= SW_ADDR;  m_rw <= 1'b1; m_wdata <= 8'h00;    end
                            SL_LED:  begin m_addr <= LED_ADDR; m_rw <= 1'b0; m_wdata <= sw_value; end
                            SL_FND:  begin m_addr <= FND_ADDR; m_rw <= 1'b0; m_wdata <= sw_value; end
                            default: begin m_addr <= haddr_q;  m_rw <= 1'b0; m_wdata <= hdata_q;  end
                        endcase
                    end
                end
                S_WAIT: begin
                    if (txn_ok) begin
                        abandoned <= 1'b0;
                        state     <= S_NEXT;
                        if (slot == SL_SW) sw_value <= m_rdata;
                    end else if (txn_fail) begin
                        if (retry_cnt < RW'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + RW'(1);
                            state     <= S_ISSUE;
                        end else begin
                            if (nack_count != 8'hFF) nack_count <= nack_count + 8'd1;
                            abandoned <= 1'b1;
                            state     <= S_NEXT;
                        end
                    end else begin
                        wd <= wd + WW'(1);
                    end
                end
                S_NEXT: begin
                    retry_cnt <= '0;
                    case (slot)
                        SL_SW: begin
                            if (abandoned) begin
                                state <= S_IDLE;
                            end else begin
                                slot  <= SL_LED;
                                state <= S_ISSUE;
                            end
                        end
                        SL_LED: begin
                            slot  <= SL_FND;
                            state <= S_ISSUE;
                        end
                        SL_FND: state <= S_IDLE;
                        default: begin
                            host_done <= 1'b1;
                            host_err  <= abandoned;
                            state     <= S_IDLE;
                        end
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
